mdu_unit: RTL and testbench



---
 rtl/mdu_unit.sv | 136 +++++++++++++
 tb/tb_mdu_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit holding the HI/LO registers.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) enabled by MDU_MADD_EN.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        cmt_q, cmt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  // Operand arithmetic, evaluated only when an op is accepted in IDLE.
  logic [63:0] smul, umul;
  logic        sdiv, a_neg, b_neg;
  logic [31:0] mag_a, mag_b, uq, ur, quo, rem;

  assign smul = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign umul = {32'b0, rs_data} * {32'b0, rt_data};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign sdiv  = (op == OP_DIV);
  assign a_neg = sdiv & rs_data[31];
  assign b_neg = sdiv & rt_data[31];
  assign mag_a = a_neg ? (32'd0 - rs_data) : rs_data;
  assign mag_b = (rt_data == 32'd0) ? 32'd1 : (b_neg ? (32'd0 - rt_data) : rt_data);
  assign uq    = mag_a / mag_b;
  assign ur    = mag_a % mag_b;
  assign quo   = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem   = a_neg ? (32'd0 - ur) : ur;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    cmt_d   = cmt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (start) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            pend_d  = (op == OP_MULT) ? smul : umul;
            cmt_d   = 1'b1;
            cnt_d   = 5'(MULT_CYCLES);
            state_d = RUN;
          end
          OP_DIV, OP_DIVU: begin
            pend_d  = {rem, quo};
            cmt_d   = (rt_data != 32'd0);
            cnt_d   = 5'(DIV_CYCLES);
            state_d = RUN;
          end
`ifdef MDU_MADD_EN
          OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
            case (op)
              OP_MADD:  pend_d = {hi_q, lo_q} + smul;
              OP_MADDU: pend_d = {hi_q, lo_q} + umul;
              OP_MSUB:  pend_d = {hi_q, lo_q} - smul;
              default:  pend_d = {hi_q, lo_q} - umul;
            endcase
            cmt_d   = 1'b1;
            cnt_d   = 5'(MULT_CYCLES);
            state_d = RUN;
          end
`endif
          OP_MTHI: hi_d = rs_data;
          OP_MTLO: lo_d = rs_data;
          default: ;
        endcase
      end
      RUN: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q <= 5'd1) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
          if (cmt_q) {hi_d, lo_d} = pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      pend_q  <= 64'd0;
      cmt_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      cmt_q   <= cmt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mdu_out = (op == OP_MFHI) ? hi_q : ((op == OP_MFLO) ? lo_q : 32'd0);

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, hand-written
// busy/reset sequences, and random ops against an arithmetic reference model.
module tb_mdu_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, busy;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs_data = 32'd0, rt_data = 32'd0, hi, lo, mdu_out;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .hi(hi), .lo(lo), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  // Reference model: updates m_hi/m_lo from plain 64-bit arithmetic, returns busy length.
  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    longint sa, sb, q, r;
    logic [63:0] p, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {m_hi, m_lo};
    cyc = 0;
    case (o)
      4'd1: begin p = 64'(sa * sb); {m_hi, m_lo} = p; cyc = MC; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; cyc = MC; end
      4'd3: begin
        cyc = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      4'd4: begin cyc = DC; if (b != 0) begin m_lo = a / b; m_hi = a % b; end end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      4'd9, 4'd10, 4'd11, 4'd12: if (MADD) begin
        p = (o == 4'd9 || o == 4'd11) ? 64'(sa * sb) : {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = (o <= 4'd10) ? acc + p : acc - p;
        cyc = MC;
      end
      default: ;
    endcase
  endtask

  // Issue one op, check busy for cyc cycles with hi/lo frozen, then the committed result.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ohi, input logic [31:0] olo,
                        input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    step();
    start = 1'b0; op = 4'd0;
    for (int i = 0; i < cyc; i++) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("hi_frozen", hi, ohi);
      chk("lo_frozen", lo, olo);
      step();
    end
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("hi", hi, ehi);
    chk("lo", lo, elo);
    chk("mdu_nop", mdu_out, 32'd0);
    op = 4'd7; #1 chk("mfhi", mdu_out, ehi);
    op = 4'd8; #1 chk("mflo", mdu_out, elo);
    op = 4'd0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          cyc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] ohi, olo, a, b;
    logic [3:0]  o;
    int cyc;

    tbl[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    tbl[1] = '{4'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MC};
    tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    tbl[3] = '{4'd4, 32'd7,        32'd2,        32'd1,        32'd3,        DC};
    tbl[4] = '{4'd5, 32'h1234,     32'd0,        32'h1234,     32'd3,        0};
    tbl[5] = '{4'd3, 32'd99,       32'd0,        32'h1234,     32'd3,        DC};
    tbl[6] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DC};
    tbl[7] = '{4'd5, 32'd0,        32'd0,        32'd0,        32'h80000000, 0};
    tbl[8] = '{4'd6, 32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFF, 0};
    tbl[9] = MADD ? '{4'd10, 32'd1, 32'd1, 32'd1, 32'd0,        MC}
                  : '{4'd10, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 0};

    #12;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    ohi = 32'd0; olo = 32'd0;
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, ohi, olo, tbl[i].ehi, tbl[i].elo, tbl[i].cyc);
      ohi = tbl[i].ehi; olo = tbl[i].elo;
    end
    m_hi = ohi; m_lo = olo;

    // Starts while busy (MTLO, second MULT) must be ignored.
    start = 1'b1; op = 4'd1; rs_data = 32'h00010000; rt_data = 32'h00010000;
    step();
    op = 4'd6; rs_data = 32'hAAAA;
    step();
    op = 4'd1; rs_data = 32'd7; rt_data = 32'd7;
    step();
    start = 1'b0; op = 4'd0;
    for (int i = 0; i < MC - 2; i++) begin
      chk("ign_busy", {31'd0, busy}, 32'd1);
      chk("ign_lo_frozen", lo, m_lo);
      step();
    end
    chk("ign_busy_done", {31'd0, busy}, 32'd0);
    chk("ign_hi", hi, 32'd1);
    chk("ign_lo", lo, 32'd0);
    m_hi = 32'd1; m_lo = 32'd0;

    // Reset mid-run clears everything before the next edge.
    start = 1'b1; op = 4'd2; rs_data = 32'd3; rt_data = 32'd3;
    step();
    start = 1'b0; op = 4'd0;
    step();
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    step();
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    run_op(4'd5, 32'h55, 32'd0, 32'd0, 32'd0, 32'h55, 32'd0, 0);
    m_hi = 32'h55;

    // Random ops against the reference model.
    for (int n = 0; n < 60; n++) begin
      o = 4'($urandom_range(1, 12));
      if (o == 4'd7 || o == 4'd8) o = 4'd1;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20)) - 32'd10;
      ohi = m_hi; olo = m_lo;
      model(o, a, b, cyc);
      run_op(o, a, b, ohi, olo, m_hi, m_lo, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
